hazard_unit_mc: RTL and testbench
=================================

Name: hazard_unit_mc

Overview:
Parametrised hazard unit for the pipelined ARM core. It provides per-operand E-stage forwarding for NSRC source operands, load-use stall, and branch/PC-write flush. It adds a multi-cycle execute stall for the iterative multiplier: the unit holds F/D/E and bubbles M until the operation completes. It sits beside the datapath and drives the pipeline register enables and clears.

Parameters:
NSRC, 3, number of source operands per instruction (Rn, Rm, Rs)
RW, 4, register address width
MUL_LAT, 4, cycles a multi-cycle op occupies E (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
RAD  in  NSRC*RW  decode-stage source register addresses, operand i at [i*RW +: RW]
UseD  in  NSRC  decode operand i actually read
RAE  in  NSRC*RW  execute-stage source register addresses
UseE  in  NSRC  execute operand i actually read
WA3E, WA3M, WA3W  in  RW each  destination register per stage
RegWriteE, RegWriteM, RegWriteW  in  1 each  stage writes register file
MemtoRegE  in  1  E-stage instruction is a load
MulStartE  in  1  E-stage instruction is a multi-cycle op, first cycle in E
BranchTakenE  in  1  branch resolved taken in E
PCSrcW  in  1  write to PC retiring in W
ForwardE  out  2*NSRC  per operand: 00 register file, 01 ResultW, 10 ALUOutM
StallF, StallD, StallE  out  1 each  hold pipeline register
FlushD, FlushE, FlushM  out  1 each  clear pipeline register to bubble
MulBusy  out  1  multi-cycle op in progress

Behaviour:
- Forwarding is combinational, per operand i, independent of stalls.
  - Match M = UseE[i] & RegWriteM & RAE_i==WA3M. Match W is the same with W signals.
  - M has priority over W. Use=0 forces 00.
- LDRStall = RegWriteE & MemtoRegE & OR over i of (UseD[i] & RAD_i==WA3E).
- FSM states IDLE and BUSY with down-counter cnt, width clog2(MUL_LAT)+1.
  - IDLE: if MulStartE & MUL_LAT>1, load cnt=MUL_LAT-1 and go to BUSY. Otherwise stay.
  - BUSY: decrement cnt each cycle. When cnt==1, go to IDLE next cycle with cnt=0.
  - MulStartE is ignored in BUSY.
- MulHold = MulStartE & (state==IDLE) & MUL_LAT>1, OR state==BUSY. The op occupies E exactly MUL_LAT cycles.
- Outputs:
  - StallF = StallD = LDRStall | MulHold
  - StallE = MulHold
  - FlushM = MulHold
  - FlushE = (LDRStall | BranchTakenE) & ~MulHold
  - FlushD = PCSrcW | BranchTakenE
  - MulBusy = (state==BUSY)
- Priority: a hold overrides load-use bubble insertion into E, so E holds and is not flushed. BranchTakenE & MulStartE together is illegal; this is checked by assertion.
- MUL_LAT==1: FSM never leaves IDLE and the block degenerates to the single-cycle hazard behaviour.
- Reset (reset==0 at a clk edge): state=IDLE, cnt=0. This applies mid-operation and releases the stall the next cycle. All outputs are combinational from state and inputs, so with idle inputs after reset every output is 0.
- Equal addresses across operands are handled independently. The R15 address gets no special treatment; the datapath sets Use=0 for PC reads.

Decomposition:
- Package hazard_pkg:
  - typedef fwd_sel_t (enum 2-bit: FWD_RF=00, FWD_W=01, FWD_M=10)
  - typedef mc_state_t (IDLE, BUSY)
  - function match(ra, wa, we, use)
- One sub-module, fwd_sel, instantiated NSRC times via generate: one operand's match and priority logic.

Test Plan:
- ADD r1 in M, ADD r1 in W, RAE operand0=r1 with UseE=1 -> ForwardE[1:0]=10. Remove the M write -> 01. Set UseE[0]=0 -> 00.
- LDR r2 in E (RegWriteE=MemtoRegE=1), RAD operand1=r2, UseD[1]=1 -> StallF=StallD=FlushE=1 for one cycle. Same with UseD[1]=0 -> all 0.
- MUL_LAT=4, MulStartE pulse -> StallF/D/E and FlushM high for exactly 4 cycles, MulBusy high for cycles 2-4, then all 0. A second MulStartE during BUSY has no effect.
- MUL_LAT=4, reset=0 on the 2nd busy cycle -> next cycle state=IDLE and StallE=0.
- BranchTakenE=1 while idle -> FlushD=FlushE=1, no stalls. PCSrcW=1 alone -> FlushD=1 only.
- LDRStall condition during BUSY -> FlushE=0, StallE=1 (the hold wins).

Source files
------------

// File: rtl/hazard_pkg.sv
// Hazard unit shared types: forwarding selects, multiply FSM states
// and the register-match helper used by forwarding and load-use.
package hazard_pkg;

  localparam int unsigned AW = 16;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_t;

  // Addresses are zero-extended to AW by the caller.
  function automatic logic match(
    input logic [AW-1:0] ra,
    input logic [AW-1:0] wa,
    input logic          we,
    input logic          used
  );
    return used & we & (ra == wa);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one execute-stage source operand.
// M-stage result wins over W-stage result.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int RW = 4
) (
  input  logic [RW-1:0] ra,
  input  logic          used,
  input  logic [RW-1:0] wa_m,
  input  logic          we_m,
  input  logic [RW-1:0] wa_w,
  input  logic          we_w,
  output fwd_sel_t      sel
);

  logic hit_m;
  logic hit_w;

  assign hit_m = match(AW'(ra), AW'(wa_m), we_m, used);
  assign hit_w = match(AW'(ra), AW'(wa_w), we_w, used);

  always_comb begin
    sel = FWD_RF;
    priority case (1'b1)
      hit_m:   sel = FWD_M;
      hit_w:   sel = FWD_W;
      default: sel = FWD_RF;
    endcase
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: forwarding, load-use stall, branch flush
// and a multi-cycle hold of F/D/E for the iterative multiplier.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int NSRC    = 3,
  parameter int RW      = 4,
  parameter int MUL_LAT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSRC*RW-1:0]   RAD,
  input  logic [NSRC-1:0]      UseD,
  input  logic [NSRC*RW-1:0]   RAE,
  input  logic [NSRC-1:0]      UseE,
  input  logic [RW-1:0]        WA3E,
  input  logic [RW-1:0]        WA3M,
  input  logic [RW-1:0]        WA3W,
  input  logic                 RegWriteE,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 MemtoRegE,
  input  logic                 MulStartE,
  input  logic                 BranchTakenE,
  input  logic                 PCSrcW,
  output logic [2*NSRC-1:0]    ForwardE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushM,
  output logic                 MulBusy
);

  localparam int   CW = $clog2(MUL_LAT) + 1;
  localparam logic MC = 1'(MUL_LAT > 1);

  for (genvar i = 0; i < NSRC; i++) begin : g_fwd
    fwd_sel_t sel;
    fwd_sel #(.RW(RW)) u_fwd (
      .ra   (RAE[i*RW +: RW]),
      .used (UseE[i]),
      .wa_m (WA3M),
      .we_m (RegWriteM),
      .wa_w (WA3W),
      .we_w (RegWriteW),
      .sel  (sel)
    );
    assign ForwardE[2*i +: 2] = sel;
  end

  logic ld_hit;
  logic ldr_stall;

  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      ld_hit = ld_hit |
        match(AW'(RAD[i*RW +: RW]), AW'(WA3E), 1'b1, UseD[i]);
    end
  end

  assign ldr_stall = RegWriteE & MemtoRegE & ld_hit;

  mc_state_t      state;
  mc_state_t      state_n;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // cnt holds the remaining BUSY cycles after the first E cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (MulStartE && MC) begin
          state_n = BUSY;
          cnt_n   = CW'(MUL_LAT - 1);
        end
      end
      BUSY: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  logic mul_hold;

  assign mul_hold = (MulStartE & (state == IDLE) & MC)
                  | (state == BUSY);

  assign StallF  = ldr_stall | mul_hold;
  assign StallD  = ldr_stall | mul_hold;
  assign StallE  = mul_hold;
  assign FlushM  = mul_hold;
  assign FlushE  = (ldr_stall | BranchTakenE) & ~mul_hold;
  assign FlushD  = PCSrcW | BranchTakenE;
  assign MulBusy = (state == BUSY);

  // A taken branch cannot coincide with a multiply entering E.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(BranchTakenE && MulStartE));
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed scoreboard bench for hazard_unit_mc (NSRC=3, RW=4,
// MUL_LAT=4); expectations queued by stimulus, checked at negedge.
module tb_hazard_unit_mc;

  localparam int NSRC = 3;
  localparam int RW   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NSRC*RW-1:0] RAD, RAE;
  logic [NSRC-1:0]   UseD, UseE;
  logic [RW-1:0]     WA3E, WA3M, WA3W;
  logic              RegWriteE, RegWriteM, RegWriteW;
  logic              MemtoRegE, MulStartE, BranchTakenE, PCSrcW;
  logic [2*NSRC-1:0] ForwardE;
  logic              StallF, StallD, StallE;
  logic              FlushD, FlushE, FlushM, MulBusy;

  hazard_unit_mc #(.NSRC(NSRC), .RW(RW), .MUL_LAT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .RAD          (RAD),
    .UseD         (UseD),
    .RAE          (RAE),
    .UseE         (UseE),
    .WA3E         (WA3E),
    .WA3M         (WA3M),
    .WA3W         (WA3W),
    .RegWriteE    (RegWriteE),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .MemtoRegE    (MemtoRegE),
    .MulStartE    (MulStartE),
    .BranchTakenE (BranchTakenE),
    .PCSrcW       (PCSrcW),
    .ForwardE     (ForwardE),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushM       (FlushM),
    .MulBusy      (MulBusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] fwd;
    logic [6:0] ctl;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   fails  = 0;

  // ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy}
  initial begin
    exp_t       e;
    logic [6:0] ctl;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e   = sbq.pop_front();
        ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy};
        checks++;
        if (ForwardE !== e.fwd) begin
          fails++;
          $display("FAIL %s ForwardE: got %b want %b",
                   e.name, ForwardE, e.fwd);
        end
        checks++;
        if (ctl !== e.ctl) begin
          fails++;
          $display("FAIL %s ctl: got %b want %b",
                   e.name, ctl, e.ctl);
        end
      end
    end
  end

  task automatic idle_in();
    RAD = '0; RAE = '0; UseD = '0; UseE = '0;
    WA3E = '0; WA3M = '0; WA3W = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MulStartE = 0; BranchTakenE = 0; PCSrcW = 0;
  endtask

  task automatic cyc(input string name, input logic [5:0] fwd,
                     input logic [6:0] ctl);
    exp_t e;
    e.name = name;
    e.fwd  = fwd;
    e.ctl  = ctl;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_in();
    reset = 0;
    @(posedge clk);
    #1;
    cyc("reset", 6'b0, 7'b0);
    reset = 1;
    cyc("idle", 6'b0, 7'b0);

    // forwarding
    RAE = {4'd7, 4'd5, 4'd1}; UseE = 3'b001;
    WA3M = 4'd1; RegWriteM = 1; WA3W = 4'd1; RegWriteW = 1;
    cyc("fwd_m_prio", 6'b000010, 7'b0);
    RegWriteM = 0;
    cyc("fwd_w", 6'b000001, 7'b0);
    UseE = 3'b000;
    cyc("fwd_unused", 6'b000000, 7'b0);
    RAE = {4'd3, 4'd3, 4'd1}; UseE = 3'b111;
    RegWriteM = 1; WA3M = 4'd1; WA3W = 4'd3;
    cyc("fwd_multi", 6'b010110, 7'b0);
    idle_in();

    // load-use
    RegWriteE = 1; MemtoRegE = 1; WA3E = 4'd2;
    RAD = {4'd0, 4'd2, 4'd0}; UseD = 3'b010;
    cyc("ldr_stall", 6'b0, 7'b1100100);
    UseD = 3'b000;
    cyc("ldr_unused", 6'b0, 7'b0);
    UseD = 3'b010; MemtoRegE = 0;
    cyc("not_load", 6'b0, 7'b0);
    idle_in();
    cyc("ldr_clear", 6'b0, 7'b0);

    // multi-cycle op, second start ignored
    MulStartE = 1;
    cyc("mul_c1", 6'b0, 7'b1110010);
    MulStartE = 0;
    cyc("mul_c2", 6'b0, 7'b1110011);
    MulStartE = 1;
    cyc("mul_c3", 6'b0, 7'b1110011);
    MulStartE = 0;
    cyc("mul_c4", 6'b0, 7'b1110011);
    cyc("mul_done", 6'b0, 7'b0);

    // reset mid-operation
    MulStartE = 1;
    cyc("mrst_c1", 6'b0, 7'b1110010);
    MulStartE = 0;
    cyc("mrst_c2", 6'b0, 7'b1110011);
    reset = 0;
    cyc("mrst_c3", 6'b0, 7'b1110011);
    reset = 1;
    cyc("mrst_rel", 6'b0, 7'b0);

    // branch / PC write flushes
    BranchTakenE = 1;
    cyc("branch", 6'b0, 7'b0001100);
    BranchTakenE = 0; PCSrcW = 1;
    cyc("pcsrcw", 6'b0, 7'b0001000);
    PCSrcW = 0;

    // load-use during BUSY: hold wins
    MulStartE = 1;
    cyc("hold_c1", 6'b0, 7'b1110010);
    MulStartE = 0;
    RegWriteE = 1; MemtoRegE = 1; WA3E = 4'd2;
    RAD = {4'd0, 4'd2, 4'd0}; UseD = 3'b010;
    RAE = {4'd0, 4'd0, 4'd9}; UseE = 3'b001;
    WA3W = 4'd9; RegWriteW = 1;
    cyc("hold_ldr", 6'b000001, 7'b1110011);
    idle_in();
    cyc("hold_c3", 6'b0, 7'b1110011);
    cyc("hold_c4", 6'b0, 7'b1110011);
    cyc("hold_done", 6'b0, 7'b0);

    repeat (3) @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
